serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..8.
REQ-002 Parameter PARITY_EN, default 1, 1 = a parity bit follows the data bits, 0 = no parity bit.
REQ-003 Parameter ODD_PARITY, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-004 Port clock, input, 1, single system clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset; 0 resets all state immediately.
REQ-006 Port din, input, 1, serial bit stream, driven from the registered output of the upstream dff stage.
REQ-007 Port bit_en, input, 1, sample strobe; din is evaluated only on clock edges where bit_en = 1.
REQ-008 Port byte_out, output, 8, last correctly received data word, LSB-aligned, upper unused bits 0.
REQ-009 Port byte_valid, output, 1, one-clock pulse marking a new good word on byte_out.
REQ-010 Port frame_err, output, 1, one-clock pulse marking a rejected frame (parity or stop error).
REQ-011 Port busy, output, 1, 1 whenever the FSM is not in IDLE.
REQ-012 Port err_count, output, 8, saturating count of rejected frames.

Function
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY, STOP, WAIT_HIGH; all transitions occur only on edges with bit_en = 1, except the pulse clearing in REQ-023.
REQ-014 IDLE: din = 0 SHALL move to DATA with the bit counter cleared; din = 1 SHALL stay in IDLE.
REQ-015 DATA: each sampled bit SHALL shift into the shift register LSB-first; after DATA_BITS samples the FSM SHALL go to PARITY if PARITY_EN = 1, else to STOP.
REQ-016 PARITY: the sampled bit SHALL be compared with the XOR of the data bits, inverted if ODD_PARITY = 1; a mismatch SHALL set an internal parity-error flag; the FSM SHALL go to STOP.
REQ-017 STOP: din = 1 with no parity error SHALL load byte_out and pulse byte_valid on the following clock edge, then go to IDLE.
REQ-018 STOP: din = 1 with a parity error SHALL pulse frame_err, leave byte_out unchanged, and go to IDLE.
REQ-019 STOP: din = 0 (break or framing error) SHALL pulse frame_err, leave byte_out unchanged, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH: the FSM SHALL stay until a sampled din = 1, then go to IDLE; a low din in this state SHALL never be treated as a start bit.
REQ-021 Back-to-back frames: a start bit sampled on the first bit_en after a good stop bit SHALL be accepted with no idle gap required.
REQ-022 Frame latency: byte_valid SHALL assert exactly one clock after the bit_en edge that sampled the stop bit.
REQ-023 byte_valid and frame_err SHALL each be high for exactly one clock, independent of bit_en, and SHALL never be high together.
REQ-024 err_count SHALL increment by 1 on each frame_err pulse and saturate at 255.
REQ-025 byte_out SHALL hold its value between valid pulses, including across error frames.

Reset
REQ-026 reset = 0 SHALL, asynchronously, force state IDLE, byte_out = 0, byte_valid = 0, frame_err = 0, busy = 0, err_count = 0, and clear the bit counter, shift register and parity flag.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no byte_valid and no frame_err pulse; reception SHALL restart only on a new start bit after reset releases.

Verification
REQ-028 Defaults, frame 0 / 1010_0101 LSB-first (0xA5) / parity 0 / stop 1, with bit_en every clock -> byte_out = 0xA5, one-clock byte_valid, err_count = 0.
REQ-029 Defaults, 0x3C sent with parity bit 1 -> frame_err pulse, byte_out keeps the previous value, err_count increments by 1.
REQ-030 Defaults, 0x81 with stop bit 0, din held 0 for 5 bit_en, then 1, then a valid 0x42 frame -> one frame_err, no false start while din is low, then byte_out = 0x42.
REQ-031 bit_en pulsing 1 clock in 4, two back-to-back frames 0x11 and 0xEE -> two byte_valid pulses in order, busy low only between bit_en edges after each stop bit.
REQ-032 reset driven low after the 4th data bit, then released and a frame 0x7E sent -> no pulse during the aborted frame, outputs at reset values, then byte_out = 0x7E.
REQ-033 300 consecutive parity-error frames -> err_count reaches and stays at 255.

Source files
------------

// File: rtl/serial_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_frame_rx : strobed serial frame receiver (start/data/parity/stop) |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module serial_frame_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       din,
  input  logic       bit_en,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       ODD_BIT  = 1'(ODD_PARITY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DATA      = 3'd1,
    S_PARITY    = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;

    if (bit_en) begin
      case (state_q)
        S_IDLE: begin
          if (!din) begin
            state_d   = S_DATA;
            cnt_d     = 3'd0;
            par_err_d = 1'b0;
          end
        end
        S_DATA: begin
          // Insert at the top of the DATA_BITS field so the word ends up LSB-aligned.
          shift_d              = shift_q >> 1;
          shift_d[DATA_BITS-1] = din;
          if (cnt_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          if (din != ((^shift_q[DATA_BITS-1:0]) ^ ODD_BIT)) begin
            par_err_d = 1'b1;
          end
          state_d = S_STOP;
        end
        S_STOP: begin
          if (din && !par_err_q) begin
            byte_out_d   = shift_q;
            byte_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = din ? S_IDLE : S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (din) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (frame_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      shift_q      <= 8'd0;
      par_err_q    <= 1'b0;
      byte_out_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// Bench for serial_frame_rx: frame-level reference model plus per-cycle compare.
module tb_serial_frame_rx;

  localparam int DATA_BITS  = 8;
  localparam int PARITY_EN  = 1;
  localparam int ODD_PARITY = 0;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b1;
  logic       bit_en = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] err_count;

  serial_frame_rx #(
    .DATA_BITS (DATA_BITS),
    .PARITY_EN (PARITY_EN),
    .ODD_PARITY(ODD_PARITY)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .bit_en    (bit_en),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Frame-level model: expected output values derived from whole-frame outcomes.
  logic [7:0] m_byte_out = 8'd0;
  int         m_errs = 0;
  logic       m_busy = 1'b0;
  int         m_valid_cyc = -1;
  int         m_err_cyc = -1;

  int         n_valid = 0;
  int         n_ferr = 0;
  logic [7:0] got_q[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("byte_valid", {7'd0, byte_valid}, {7'd0, (cyc == m_valid_cyc)});
    chk("frame_err", {7'd0, frame_err}, {7'd0, (cyc == m_err_cyc)});
    chk("byte_out", byte_out, m_byte_out);
    chk("err_count", err_count, (m_errs > 255) ? 8'd255 : 8'(m_errs));
    chk("busy", {7'd0, busy}, {7'd0, m_busy});
    if (byte_valid) begin
      n_valid++;
      got_q.push_back(byte_out);
    end
    if (frame_err) n_ferr++;
  end

  task automatic sample(input logic b);
    din    = b;
    bit_en = 1'b1;
    @(posedge clock);
    #1;
    bit_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Sample while the receiver is idle or waiting for a high line.
  task automatic line_bit(input logic b);
    sample(b);
    if (b) m_busy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par,
                            input logic stop, input int gap);
    logic p;
    logic good;
    p = (^data[DATA_BITS-1:0]) ^ 1'(ODD_PARITY) ^ bad_par;
    sample(1'b0);
    m_busy = 1'b1;
    idle(gap - 1);
    for (int i = 0; i < DATA_BITS; i++) begin
      sample(data[i]);
      idle(gap - 1);
    end
    if (PARITY_EN != 0) begin
      sample(p);
      idle(gap - 1);
    end
    sample(stop);
    good = stop && !((PARITY_EN != 0) && bad_par);
    if (good) begin
      m_byte_out  = data;
      m_valid_cyc = cyc;
      m_busy      = 1'b0;
    end else begin
      m_err_cyc = cyc;
      m_errs++;
      m_busy = !stop;
    end
    idle(gap - 1);
  endtask

  initial begin
    int v0;
    int e0;
    reset = 1'b0;
    idle(3);
    chk("reset_byte_out", byte_out, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    reset = 1'b1;
    line_bit(1'b1);
    line_bit(1'b1);

    // Good frame 0xA5, bit_en every clock
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    idle(2);
    chk("a5_byte_out", byte_out, 8'hA5);
    chk("a5_err_count", err_count, 8'd0);
    chk("a5_valid_pulses", 8'(n_valid), 8'd1);

    // 0x3C with wrong parity bit 1
    send_frame(8'h3C, 1'b1, 1'b1, 1);
    idle(2);
    chk("par_byte_out", byte_out, 8'hA5);
    chk("par_err_count", err_count, 8'd1);
    chk("par_ferr_pulses", 8'(n_ferr), 8'd1);

    // Stop error, line held low, then a good frame
    v0 = n_valid;
    e0 = n_ferr;
    send_frame(8'h81, 1'b0, 1'b0, 1);
    repeat (5) line_bit(1'b0);
    line_bit(1'b1);
    send_frame(8'h42, 1'b0, 1'b1, 1);
    idle(2);
    chk("brk_ferr_pulses", 8'(n_ferr - e0), 8'd1);
    chk("brk_valid_pulses", 8'(n_valid - v0), 8'd1);
    chk("brk_byte_out", byte_out, 8'h42);
    chk("brk_err_count", err_count, 8'd2);

    // Back-to-back frames with bit_en one clock in four
    v0 = n_valid;
    send_frame(8'h11, 1'b0, 1'b1, 4);
    send_frame(8'hEE, 1'b0, 1'b1, 4);
    idle(2);
    chk("b2b_valid_pulses", 8'(n_valid - v0), 8'd2);
    if (got_q.size() >= 2) begin
      chk("b2b_first", got_q[got_q.size()-2], 8'h11);
      chk("b2b_second", got_q[got_q.size()-1], 8'hEE);
    end else begin
      chk("b2b_queue_size", 8'(got_q.size()), 8'd2);
    end

    // Reset after the 4th data bit of a frame
    v0 = n_valid;
    e0 = n_ferr;
    sample(1'b0);
    m_busy = 1'b1;
    sample(1'b0);
    sample(1'b1);
    sample(1'b1);
    sample(1'b1);
    reset       = 1'b0;
    m_byte_out  = 8'd0;
    m_errs      = 0;
    m_busy      = 1'b0;
    m_valid_cyc = -1;
    m_err_cyc   = -1;
    idle(2);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_err_count", err_count, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    reset = 1'b1;
    line_bit(1'b1);
    send_frame(8'h7E, 1'b0, 1'b1, 1);
    idle(2);
    chk("rst_ferr_pulses", 8'(n_ferr - e0), 8'd0);
    chk("rst_valid_pulses", 8'(n_valid - v0), 8'd1);
    chk("rst_new_byte", byte_out, 8'h7E);

    // Error counter saturation
    for (int k = 0; k < 300; k++) begin
      send_frame(8'(k), 1'b1, 1'b1, 1);
      if (k == 254) chk("sat_at_255", err_count, 8'd255);
    end
    idle(2);
    chk("sat_final", err_count, 8'd255);
    chk("sat_byte_out", byte_out, 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
